alu_arbiter: RTL and testbench

//  Shares the single mini-CPU ALU between two requesters, e.g. the control unit and a debug/test port.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 32 +++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the mini-CPU ALU and the arbiter that lets
// two requesters share it: opcodes, FSM state encodings and default width.
package alu_pkg;

  localparam int DATA_W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: (a, b, op) -> (result, zero). Results wrap
// modulo 2^DATA_W and shifts are logical; B is unused by NOT and the shifts.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Opcode decode and zero flag
  always_comb begin
    result = {DATA_W{1'b0}};
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
      OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
      default: result = {DATA_W{1'b0}};
    endcase
    zero = (result == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one alu_core between two requesters, with
// a registered, backpressured response tagged by requester ID.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  state_t              state_r;
  logic                last_grant_r;
  logic [2:0]          op_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                id_r;
  logic                rsp_valid_r;
  logic                rsp_id_r;
  logic [DATA_W-1:0]   rsp_result_r;
  logic                rsp_zero_r;
  logic                busy_r;
  logic [CNT_W-1:0]    ops_done_r;

  logic                grant0_s;
  logic                grant1_s;
  logic [2:0]          sel_op_s;
  logic [DATA_W-1:0]   sel_a_s;
  logic [DATA_W-1:0]   sel_b_s;
  logic [DATA_W-1:0]   alu_result_s;
  logic                alu_zero_s;

  // Round-robin grant; on contention the requester not served last wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_grant_r;
        grant1_s = ~last_grant_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operand mux feeding the capture registers
  always_comb begin
    sel_op_s = req0_op;
    sel_a_s  = req0_a;
    sel_b_s  = req0_b;
    if (grant1_s) begin
      sel_op_s = req1_op;
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
    end else begin
      sel_op_s = req0_op;
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
    end
  end

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .op     (op_r),
    .a      (a_r),
    .b      (b_r),
    .result (alu_result_s),
    .zero   (alu_zero_s)
  );

  // Accept/execute/respond FSM with capture, response and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      op_r         <= 3'b000;
      a_r          <= {DATA_W{1'b0}};
      b_r          <= {DATA_W{1'b0}};
      id_r         <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {DATA_W{1'b0}};
      rsp_zero_r   <= 1'b0;
      busy_r       <= 1'b0;
      ops_done_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            op_r         <= sel_op_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            id_r         <= grant1_s;
            last_grant_r <= grant1_s;
            busy_r       <= 1'b1;
            state_r      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_r <= alu_result_s;
          rsp_zero_r   <= alu_zero_s;
          rsp_id_r     <= id_r;
          rsp_valid_r  <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          // Response fields stay frozen until the consumer takes them
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            ops_done_r  <= ops_done_r + CNT_W'(1);
            state_r     <= IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_zero   = rsp_zero_r;
  assign busy       = busy_r;
  assign ops_done   = ops_done_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised and directed bench for alu_arbiter: a transaction-level model
// predicts grants and results, a separate monitor scores responses.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [3:0] rsp_result;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy), .ops_done(ops_done)
  );

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // stimulus variables and transaction-level model state
  logic       rst_v, rr_v;
  logic       v[2];
  logic [2:0] op_v[2];
  logic [3:0] a_v[2], b_v[2], exp_v[2];
  int         m_phase;   // 0 free, 1 computing, 2 response offered
  logic       m_last;
  int         last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int r;
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    case (op)
      3'd0: r = ai + bi;
      3'd1: r = ai - bi + 16;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 15 - ai;
      3'd6: r = ai * 2;
      3'd7: r = ai / 2;
      default: r = 0;
    endcase
    return 4'(r % 16);
  endfunction

  task automatic step();
    int   winner;
    logic e0, e1;
    exp_t e;
    @(negedge clk);
    reset = rst_v; rsp_ready = rr_v;
    req0_valid = v[0]; req0_op = op_v[0]; req0_a = a_v[0]; req0_b = b_v[0];
    req1_valid = v[1]; req1_op = op_v[1]; req1_a = a_v[1]; req1_b = b_v[1];
    #1;
    last_acc = -1;
    if (rst_v) begin
      m_phase = 0;
      m_last  = 1'b1;
      exp_q.delete();
    end else begin
      winner = (v[0] && v[1]) ? (m_last ? 0 : 1) : (v[1] ? 1 : 0);
      e0 = (m_phase == 0) && v[0] && (winner == 0);
      e1 = (m_phase == 0) && v[1] && (winner == 1);
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
      if (m_phase == 0 && (v[0] || v[1])) begin
        e.id   = (winner == 1);
        e.res  = exp_v[winner];
        e.zero = (exp_v[winner] == 4'd0);
        exp_q.push_back(e);
        m_last   = (winner == 1);
        m_phase  = 1;
        last_acc = winner;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && rr_v) begin
        m_phase = 0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] e);
    v[i] = 1'b1; op_v[i] = op; a_v[i] = a; b_v[i] = b; exp_v[i] = e;
  endtask

  task automatic issue_wait(input int i);
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (last_acc == i) begin
        v[i] = 1'b0;
        done = 1;
      end
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    bit done = 0;
    v[0] = 1'b0; v[1] = 1'b0; rr_v = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      step();
      if (m_phase == 0 && exp_q.size() == 0) done = 1;
    end
    if (!done) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_v = 1'b1; v[0] = 1'b0; v[1] = 1'b0;
    repeat (n) step();
    rst_v = 1'b0;
  endtask

  // monitor: scores every response handshake and checks holding behaviour
  initial begin
    logic       held;
    exp_t       h, e;
    logic [7:0] exp_ops;
    held = 1'b0;
    exp_ops = 8'd0;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b0) begin
        held = 1'b0;
        exp_ops = 8'd0;
      end else begin
        chk("ops_done", 32'(ops_done), 32'(exp_ops));
        if (rsp_valid) begin
          if (held) begin
            chk("hold_id", 32'(rsp_id), 32'(h.id));
            chk("hold_result", 32'(rsp_result), 32'(h.res));
            chk("hold_zero", 32'(rsp_zero), 32'(h.zero));
          end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_id", 32'(rsp_id), 32'(e.id));
              chk("rsp_result", 32'(rsp_result), 32'(e.res));
              chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
            end
            exp_ops = exp_ops + 8'd1;
            held = 1'b0;
          end else begin
            held = 1'b1;
            h.id = rsp_id; h.res = rsp_result; h.zero = rsp_zero;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; op_v[i] = 3'd0; a_v[i] = 4'd0; b_v[i] = 4'd0; exp_v[i] = 4'd0;
    end
    rr_v = 1'b1; m_phase = 0; m_last = 1'b1; last_acc = -1;

    // reset state
    do_reset(2);
    step();
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_rsp_result", 32'(rsp_result), 32'd0);
    chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("reset_ops_done", 32'(ops_done), 32'd0);

    // single ADD on requester 0
    set_req(0, OP_ADD, 4'd4, 4'd5, 4'd9);
    issue_wait(0);
    drain();
    chk("add_ops_done", 32'(ops_done), 32'd1);

    // contention straight after reset: requester 0 first
    do_reset(1);
    set_req(0, OP_SUB, 4'd5, 4'd5, 4'd0);
    set_req(1, OP_XOR, 4'd4, 4'd5, 4'd1);
    issue_wait(0);
    issue_wait(1);
    drain();

    // backpressure: hold rsp_ready low three cycles after rsp_valid
    rr_v = 1'b0;
    set_req(1, OP_OR, 4'd10, 4'd5, 4'd15);
    issue_wait(1);
    step();
    repeat (3) step();
    chk("bp_busy", 32'(busy), 32'd1);
    drain();

    // reset during EXEC drops the op, then requester 0 wins
    set_req(1, OP_AND, 4'd12, 4'd10, 4'd8);
    issue_wait(1);
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    set_req(0, OP_ADD, 4'd1, 4'd2, 4'd3);
    set_req(1, OP_ADD, 4'd7, 4'd7, 4'd14);
    step();
    chk("post_reset_grant0", 32'(req0_ready), 32'd1);
    chk("post_reset_grant1", 32'(req1_ready), 32'd0);
    v[0] = 1'b0;
    issue_wait(1);
    drain();

    // edge values
    set_req(0, OP_ADD, 4'd15, 4'd1, 4'd0);  issue_wait(0);
    set_req(1, OP_SUB, 4'd3,  4'd5, 4'd14); issue_wait(1);
    set_req(0, OP_NOT, 4'd4,  4'd9, 4'd11); issue_wait(0);
    set_req(1, OP_SHL, 4'd9,  4'd3, 4'd2);  issue_wait(1);
    set_req(0, OP_SHR, 4'd4,  4'd6, 4'd2);  issue_wait(0);
    drain();

    // random traffic with changing valids and random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        v[i] = ($urandom_range(0, 2) != 0);
        op_v[i] = 3'($urandom_range(0, 7));
        a_v[i] = 4'($urandom_range(0, 15));
        b_v[i] = 4'($urandom_range(0, 15));
        exp_v[i] = ref_alu(op_v[i], a_v[i], b_v[i]);
      end
      rr_v = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    // 256 ops from reset: counter wraps back to zero
    do_reset(1);
    rr_v = 1'b1;
    for (int n = 0; n < 256; n++) begin
      int i;
      i = int'($urandom_range(0, 1));
      op_v[i] = 3'($urandom_range(0, 7));
      a_v[i] = 4'($urandom_range(0, 15));
      b_v[i] = 4'($urandom_range(0, 15));
      set_req(i, op_v[i], a_v[i], b_v[i], ref_alu(op_v[i], a_v[i], b_v[i]));
      issue_wait(i);
    end
    drain();
    step();
    chk("ops_done_wrap", 32'(ops_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
